// File: rtl/gold_miner_pkg.sv
// Shared definitions for the gold miner hook/object catch interface.
//   hook_state_t : hook FSM encoding, also driven on state_out
//   SCREEN_*     : playfield size used for the hook boundary test
//   DX/DY        : per-step tail displacement for each angle index (y down)
package gold_miner_pkg;

  typedef enum logic [2:0] {
    SWING   = 3'd0,
    EXTEND  = 3'd1,
    RETRACT = 3'd2,
    CARRY   = 3'd3
  } hook_state_t;

  localparam int SCREEN_WIDTH  = 480;
  localparam int SCREEN_LENGTH = 640;

  localparam logic [3:0] MODE_MAX   = 4'd10;
  localparam logic [3:0] MODE_RESET = 4'd5;

  localparam logic signed [3:0] DX [0:10] = '{
    -4'sd6, -4'sd6, -4'sd5, -4'sd4, -4'sd2, 4'sd0,
     4'sd2,  4'sd4,  4'sd5,  4'sd6,  4'sd6
  };
  localparam logic signed [3:0] DY [0:10] = '{
     4'sd0,  4'sd1,  4'sd2,  4'sd3,  4'sd4, 4'sd6,
     4'sd4,  4'sd3,  4'sd2,  4'sd1,  4'sd0
  };

endpackage

// File: rtl/hook_dir_lut.sv
// Angle index to per-step direction vector.
//   mode : angle index 0..10
//   dx   : signed x step; 0 for out-of-range mode
//   dy   : signed y step (down positive); 0 for out-of-range mode
module hook_dir_lut
  import gold_miner_pkg::*;
(
  input  logic [3:0]        mode,
  output logic signed [3:0] dx,
  output logic signed [3:0] dy
);

  always_comb begin
    dx = '0;
    dy = '0;
    if (mode <= MODE_MAX) begin
      dx = DX[mode];
      dy = DY[mode];
    end
  end

endmodule

// File: rtl/hook_controller.sv
// One miner's hook: swings an angle index, extends on fire, retracts empty
// or loaded, and drives the tail position seen by every catchable object.
//   Clk, reset         : clock, synchronous active-high reset
//   is_new_game_start  : synchronous clear, same effect as reset
//   fire               : launch key (level), honoured only while swinging
//   is_catch           : OR of all objects' catch flags, honoured only while extending
//   tailx, taily       : registered hook tail position
//   R_mode             : angle index 0..10
//   state_out          : hook_state_t encoding
//   catch_done         : one-cycle pulse when a loaded hook reaches the pivot
module hook_controller
  import gold_miner_pkg::*;
#(
  parameter logic [9:0]  PIVOT_X      = 10'd320,
  parameter logic [9:0]  PIVOT_Y      = 10'd40,
  parameter logic [31:0] SWING_PERIOD = 32'd4000000,
  parameter logic [31:0] EXT_PERIOD   = 32'd1000000,
  parameter logic [31:0] EMPTY_PERIOD = 32'd1000000,
  parameter logic [31:0] CARRY_PERIOD = 32'd2000000,
  parameter logic [6:0]  N_MAX        = 7'd80
)(
  input  logic       Clk,
  input  logic       reset,
  input  logic       is_new_game_start,
  input  logic       fire,
  input  logic       is_catch,
  output logic [9:0] tailx,
  output logic [9:0] taily,
  output logic [3:0] R_mode,
  output logic [2:0] state_out,
  output logic       catch_done
);

  localparam logic signed [11:0] X_LIM = 12'(SCREEN_LENGTH - 1);
  localparam logic signed [11:0] Y_LIM = 12'(SCREEN_WIDTH - 1);

  hook_state_t state, state_nxt;
  logic [31:0] cnt, cnt_nxt, period;
  logic [6:0]  n, n_nxt;
  logic [3:0]  mode_nxt;
  logic        dir, dir_nxt;  // 1 = angle index increasing
  logic        done_nxt, wrap, out_of_bounds;
  logic        clr;

  logic signed [3:0]  dx, dy;
  logic signed [11:0] n1_w, dx_w, dy_w, nxt_x, nxt_y;
  logic [9:0]         cur_x, cur_y;

  assign clr = reset | is_new_game_start;

  hook_dir_lut u_lut (
    .mode (R_mode),
    .dx   (dx),
    .dy   (dy)
  );

  // Current tail only needs the low 10 bits, so modular 10-bit math is exact.
  assign cur_x = PIVOT_X + {3'b0, n} * {{6{dx[3]}}, dx};
  assign cur_y = PIVOT_Y + {3'b0, n} * {{6{dy[3]}}, dy};

  // Candidate position one step further, kept signed to catch x<0.
  assign n1_w  = $signed({5'b0, n}) + 12'sd1;
  assign dx_w  = $signed({{8{dx[3]}}, dx});
  assign dy_w  = $signed({{8{dy[3]}}, dy});
  assign nxt_x = $signed({2'b0, PIVOT_X}) + n1_w * dx_w;
  assign nxt_y = $signed({2'b0, PIVOT_Y}) + n1_w * dy_w;
  assign out_of_bounds = (nxt_x < 12'sd0) || (nxt_x > X_LIM) || (nxt_y > Y_LIM);

  always_comb begin
    case (state)
      EXTEND:  period = EXT_PERIOD;
      RETRACT: period = EMPTY_PERIOD;
      CARRY:   period = CARRY_PERIOD;
      default: period = SWING_PERIOD;
    endcase
  end

  assign wrap = (cnt == period - 32'd1);

  always_comb begin
    state_nxt = state;
    mode_nxt  = R_mode;
    dir_nxt   = dir;
    n_nxt     = n;
    done_nxt  = 1'b0;
    case (state)
      SWING: begin
        if (fire) begin
          state_nxt = EXTEND;
        end else if (wrap) begin
          mode_nxt = dir ? R_mode + 4'd1 : R_mode - 4'd1;
          // Flip on arrival at an end so the next step bounces back.
          if (mode_nxt == MODE_MAX || mode_nxt == 4'd0) dir_nxt = ~dir;
        end
      end
      EXTEND: begin
        if (is_catch) begin
          state_nxt = CARRY;
        end else if (wrap) begin
          if (n == N_MAX || out_of_bounds) state_nxt = RETRACT;
          else                              n_nxt     = n + 7'd1;
        end
      end
      RETRACT: begin
        if (n == 7'd0)  state_nxt = SWING;
        else if (wrap)  n_nxt     = n - 7'd1;
      end
      CARRY: begin
        if (n == 7'd0) begin
          state_nxt = SWING;
          done_nxt  = 1'b1;
        end else if (wrap) begin
          n_nxt = n - 7'd1;
        end
      end
      default: state_nxt = SWING;
    endcase
    cnt_nxt = (wrap || state_nxt != state) ? 32'd0 : cnt + 32'd1;
  end

  always_ff @(posedge Clk) begin
    if (clr) begin
      state      <= SWING;
      R_mode     <= MODE_RESET;
      dir        <= 1'b1;
      n          <= 7'd0;
      cnt        <= 32'd0;
      catch_done <= 1'b0;
      tailx      <= PIVOT_X;
      taily      <= PIVOT_Y;
    end else begin
      state      <= state_nxt;
      R_mode     <= mode_nxt;
      dir        <= dir_nxt;
      n          <= n_nxt;
      cnt        <= cnt_nxt;
      catch_done <= done_nxt;
      tailx      <= cur_x;
      taily      <= cur_y;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_hook_controller.sv
// Directed bench for hook_controller with short sim periods.
module tb_hook_controller;

  logic       Clk = 1'b0;
  logic       reset, is_new_game_start, fire, is_catch, fire2, is_catch2;
  logic [9:0] tailx, taily, tailx2, taily2;
  logic [3:0] R_mode, R_mode2;
  logic [2:0] state_out, state2;
  logic       catch_done, catch_done2;

  int n_cmp = 0;
  int n_bad = 0;
  int last, steps, bad, gap, gapbad, first_gap, dn, saw1;

  always #5 Clk = ~Clk;

  hook_controller #(
    .SWING_PERIOD(32'd4), .EXT_PERIOD(32'd2), .EMPTY_PERIOD(32'd2), .CARRY_PERIOD(32'd4)
  ) dut (
    .Clk(Clk), .reset(reset), .is_new_game_start(is_new_game_start),
    .fire(fire), .is_catch(is_catch),
    .tailx(tailx), .taily(taily), .R_mode(R_mode),
    .state_out(state_out), .catch_done(catch_done)
  );

  hook_controller #(
    .PIVOT_X(10'd639),
    .SWING_PERIOD(32'd4), .EXT_PERIOD(32'd2), .EMPTY_PERIOD(32'd2), .CARRY_PERIOD(32'd4)
  ) dut2 (
    .Clk(Clk), .reset(reset), .is_new_game_start(is_new_game_start),
    .fire(fire2), .is_catch(is_catch2),
    .tailx(tailx2), .taily(taily2), .R_mode(R_mode2),
    .state_out(state2), .catch_done(catch_done2)
  );

  typedef struct {
    logic       fire;
    logic       is_catch;
    int         cycles;
    int         st;
    int         mode;
    int         tx;
    int         ty;
  } vec_t;

  vec_t vt[12];
  int   swing_modes[12] = '{5, 6, 7, 8, 9, 10, 9, 8, 7, 6, 5, 4};

  task automatic step(input int k);
    repeat (k) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int probe(input int sel);
    case (sel)
      0:       return int'(tailx);
      1:       return int'(taily);
      2:       return int'(R_mode);
      3:       return int'(state_out);
      4:       return int'(R_mode2);
      default: return int'(state2);
    endcase
  endfunction

  // Bounded wait; an expired bound is a failed comparison.
  task automatic wait_for(input int sel, input int target, input string nm);
    int t;
    for (t = 0; t < 1000; t++) begin
      if (probe(sel) == target) break;
      step(1);
    end
    chk({"wait_", nm}, probe(sel), target);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  // Launch at R_mode=10, catch at n=5, stop once the carry shows n=3.
  task automatic run_to_carry_n3();
    do_reset();
    wait_for(2, 10, "mode10");
    fire = 1'b1;
    step(1);
    fire = 1'b0;
    wait_for(0, 350, "tx350");
    is_catch = 1'b1;
    step(1);
    is_catch = 1'b0;
    wait_for(0, 338, "tx338");
    chk("pre_clear_state", int'(state_out), 3);
  endtask

  task automatic check_cleared(input string nm);
    chk({nm, "_state"}, int'(state_out), 0);
    chk({nm, "_tx"}, int'(tailx), 320);
    chk({nm, "_ty"}, int'(taily), 40);
    chk({nm, "_mode"}, int'(R_mode), 5);
    dn = 0;
    for (int t = 0; t < 30; t++) begin
      if (catch_done) dn++;
      step(1);
    end
    chk({nm, "_no_done"}, dn, 0);
  endtask

  initial begin
    reset = 1'b1; is_new_game_start = 1'b0;
    fire = 1'b0; is_catch = 1'b0; fire2 = 1'b0; is_catch2 = 1'b0;

    // Swing table: one row per angle step; odd rows hold is_catch high,
    // which must not disturb SWING.
    for (int i = 0; i < 12; i++) begin
      vt[i] = '{1'b0, logic'(i % 2), (i == 0) ? 0 : 4, 0, swing_modes[i], 320, 40};
    end

    step(2);
    reset = 1'b0;
    chk("reset_done", int'(catch_done), 0);
    chk("reset_state2", int'(state2), 0);
    chk("reset_tx2", int'(tailx2), 639);

    for (int i = 0; i < 12; i++) begin
      fire     = vt[i].fire;
      is_catch = vt[i].is_catch;
      step(vt[i].cycles);
      chk($sformatf("swing%0d_state", i), int'(state_out), vt[i].st);
      chk($sformatf("swing%0d_mode", i), int'(R_mode), vt[i].mode);
      chk($sformatf("swing%0d_tx", i), int'(tailx), vt[i].tx);
      chk($sformatf("swing%0d_ty", i), int'(taily), vt[i].ty);
    end
    is_catch = 1'b0;

    // Straight down, empty, with fire held through the retract.
    do_reset();
    fire = 1'b1;
    step(1);
    fire = 1'b0;
    chk("down_extend", int'(state_out), 1);
    last = 40; steps = 0; bad = 0;
    for (int t = 0; t < 400 && state_out != 3'd2; t++) begin
      step(1);
      if (int'(taily) != last) begin
        if (int'(taily) != last + 6) bad++;
        steps++;
        last = int'(taily);
      end
    end
    chk("down_retract", int'(state_out), 2);
    chk("down_stop_y", int'(taily), 478);
    chk("down_steps", steps, 73);
    chk("down_step_size", bad, 0);
    chk("down_x", int'(tailx), 320);
    fire = 1'b1;
    steps = 0; bad = 0; saw1 = 0; dn = 0;
    for (int t = 0; t < 400 && state_out != 3'd0; t++) begin
      step(1);
      if (state_out == 3'd1) saw1++;
      if (catch_done) dn++;
      if (int'(taily) != last) begin
        if (int'(taily) != last - 6) bad++;
        steps++;
        last = int'(taily);
      end
    end
    chk("ret_swing", int'(state_out), 0);
    chk("ret_fire_ignored", saw1, 0);
    chk("ret_no_done", dn, 0);
    chk("ret_steps", steps, 73);
    chk("ret_step_size", bad, 0);
    chk("ret_tx", int'(tailx), 320);
    chk("ret_ty", int'(taily), 40);
    chk("ret_mode", int'(R_mode), 5);
    step(1);
    chk("relaunch_in_swing", int'(state_out), 1);
    fire = 1'b0;

    // Loaded retract from R_mode=10.
    do_reset();
    wait_for(2, 10, "carry_mode10");
    fire = 1'b1;
    step(1);
    fire = 1'b0;
    wait_for(0, 350, "carry_tx350");
    is_catch = 1'b1;
    step(1);
    is_catch = 1'b0;
    chk("carry_state", int'(state_out), 3);
    chk("carry_hold_x", int'(tailx), 350);
    last = 350; steps = 0; bad = 0; gap = 0; gapbad = 0; first_gap = 0; dn = 0;
    for (int t = 0; t < 200 && state_out != 3'd0; t++) begin
      step(1);
      gap++;
      if (catch_done) dn++;
      if (int'(tailx) != last) begin
        if (int'(tailx) != last - 6) bad++;
        if (steps == 0) first_gap = gap;
        else if (gap != 4) gapbad++;
        steps++;
        gap = 0;
        last = int'(tailx);
      end
    end
    chk("carry_swing", int'(state_out), 0);
    chk("carry_steps", steps, 5);
    chk("carry_step_size", bad, 0);
    chk("carry_first_gap", first_gap, 5);
    chk("carry_gap", gapbad, 0);
    chk("carry_end_x", int'(tailx), 320);
    chk("carry_done_at_pivot", int'(catch_done), 1);
    step(1);
    chk("carry_done_width", int'(catch_done), 0);
    chk("carry_done_count", dn, 1);

    // N_MAX stop on the off-centre pivot.
    do_reset();
    wait_for(4, 0, "nmax_mode0");
    fire2 = 1'b1;
    step(1);
    fire2 = 1'b0;
    chk("nmax_extend", int'(state2), 1);
    wait_for(5, 2, "nmax_retract");
    chk("nmax_tx", int'(tailx2), 159);
    chk("nmax_ty", int'(taily2), 40);

    // Catch coincident with the boundary step.
    do_reset();
    fire = 1'b1;
    step(1);
    fire = 1'b0;
    wait_for(1, 478, "prio_ty478");
    is_catch = 1'b1;
    step(1);
    is_catch = 1'b0;
    chk("prio_carry", int'(state_out), 3);
    chk("prio_ty", int'(taily), 478);

    // Clear mid-carry, by reset and by new game start.
    run_to_carry_n3();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_cleared("rst_mid");
    run_to_carry_n3();
    is_new_game_start = 1'b1;
    step(1);
    is_new_game_start = 1'b0;
    check_cleared("ngs_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
